uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
Asynchronous serial receiver that converts the RX pin into parallel bytes for the TramelBlaze peripheral space. It complements the transmit path: the same baud selection, parity options and frame format (start, 8 data bits LSB first, optional parity, 1 stop). It holds one received byte with status flags until the processor acknowledges it.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; baud-table constants are computed from it
CNT_W, 19, bit-time counter width; must hold CLK_HZ/300

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
baud_sel  input  4  baud code, latched at start-bit detection
pen  input  1  parity enable, latched at start-bit detection
ohel  input  1  parity sense: 1 = odd, 0 = even; latched with pen
rd_ack  input  1  one-cycle pulse: processor has read rx_data/status
rx_data  output  8  last received byte
rxrdy  output  1  unread byte present
perr  output  1  parity error on the held byte
ferr  output  1  framing error (stop bit = 0) on the held byte
ovf  output  1  overrun: a byte completed while rxrdy was already 1
rx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Synchronizer: rx passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- Baud table: BT = (CLK_HZ + b/2)/b for each baud b.
  - Codes 0-11 select 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
  - Codes 12-15 select 115200.
  - At 100 MHz, code 8 gives BT=868 and code 4 gives BT=10417.
- Counter: cnt counts 0 upward. A "sample" occurs in the cycle where cnt == LIM-1; cnt then returns to 0.
  - In START, LIM = BT/2 (integer division).
  - In all other states, LIM = BT.
- IDLE:
  - cnt=0.
  - When rx_s==0, latch baud_sel, pen and ohel, then go to START.
- START:
  - At the sample point, rx_s==1 means a false start: return to IDLE, no flags change.
  - Otherwise go to DATA with bit index=0.
- DATA:
  - Each sample shifts rx_s into the shift register MSB; after 8 samples, bit 0 is the first bit received.
  - After the 8th sample, go to PARITY if pen==1, else STOP.
- PARITY: sample into pbit, then go to STOP.
  - Even parity: XOR of 8 data bits ^ pbit must be 0.
  - Odd parity: that XOR must be 1.
- STOP: at the sample point, go to IDLE in the same cycle; the next start can begin immediately. On the next clock edge:
  - rx_data <= shift register (loaded even on errors).
  - ferr <= ~rx_s.
  - perr <= pen & parity mismatch (0 if pen==0).
  - ovf <= rxrdy & ~rd_ack.
  - rxrdy <= 1.
  - rx_done=1 for exactly one cycle.
- Latency: rx_done asserts (BT/2) + (9 + pen)*BT + 1 cycles after the first clock where rx_s==0 is seen in IDLE.
- rd_ack without frame completion: clears rxrdy, perr, ferr and ovf; rx_data holds.
- rd_ack in the same cycle as frame completion: the completion wins. rxrdy=1, ovf=0, and perr/ferr take the new frame's values.
- Overrun: the older byte is lost; rx_data takes the newer byte and ovf=1.
- Input changes mid-frame: changes to baud_sel, pen or ohel have no effect on the frame in progress.
- Reset values: rx_data=0x00, rxrdy=0, perr=0, ferr=0, ovf=0, rx_done=0, state=IDLE, cnt=0.
- Reset mid-frame: the partial frame is discarded. If rx is still low after reset release, a start is detected 2 cycles later (synchronizer).
- Break (rx held low): yields a 0x00 frame with ferr=1. Afterwards the FSM stays in IDLE until rx_s returns high; no repeated frames are produced.

Test Plan:
- 115200 baud (code 8), pen=0, frame 0xA5 at BT=868 -> rx_done after 434+9*868+1 cycles from start detection; rx_data=0xA5, rxrdy=1, perr=ferr=ovf=0.
- pen=1, ohel=0, byte 0x03 sent with pbit=1 (wrong) -> perr=1, rx_data=0x03; same byte sent with pbit=0 -> perr=0.
- Stop bit driven 0, byte 0x7E -> ferr=1, rx_data=0x7E, rxrdy=1; then rd_ack -> rxrdy=ferr=0, rx_data still 0x7E.
- Glitch: rx low for 200 cycles at BT=868 -> no rx_done, state returns to IDLE; then valid frame 0x55 received correctly.
- Two frames 0x11 then 0x22 with no rd_ack -> rx_data=0x22, ovf=1; repeat with rd_ack pulsed in the exact rx_done cycle of frame 2 -> rxrdy=1, ovf=0.
- Assert reset during the 4th data bit of frame 0xFF, release, then send 0x3C -> all flags 0 after reset, no frame from the aborted byte, rx_data=0x3C.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop synchronizer, mid-bit sampling FSM and a one-byte
// holding register with parity/framing/overrun status, cleared by a read acknowledge.
module uart_rx_deframer #(
   parameter int CLK_HZ = 100000000,
   parameter int CNT_W  = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic [3:0] baud_sel,
   input  logic       pen,
   input  logic       ohel,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rxrdy,
   output logic       perr,
   output logic       ferr,
   output logic       ovf,
   output logic       rx_done
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic [CNT_W-1:0] bit_time(input logic [3:0] code);
      int baud;
      case (code)
         4'd0:    baud = 300;
         4'd1:    baud = 1200;
         4'd2:    baud = 2400;
         4'd3:    baud = 4800;
         4'd4:    baud = 9600;
         4'd5:    baud = 19200;
         4'd6:    baud = 38400;
         4'd7:    baud = 57600;
         4'd8:    baud = 115200;
         4'd9:    baud = 230400;
         4'd10:   baud = 460800;
         4'd11:   baud = 921600;
         default: baud = 115200;
      endcase
      return CNT_W'((CLK_HZ + baud / 2) / baud);
   endfunction

   state_t           state, state_next;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt, bt, lim;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             pbit;
   logic [3:0]       baud_q;
   logic             pen_q, ohel_q;
   logic             hold_low;
   logic             stop_q, perr_q;
   logic             sample, start_det, frame_end;

   assign bt        = bit_time(baud_q);
   assign lim       = (state == S_START) ? (bt >> 1) : bt;
   assign sample    = (state != S_IDLE) && (cnt == lim - 1'b1);
   assign start_det = (state == S_IDLE) && !rx_s && !hold_low;
   assign frame_end = (state == S_STOP) && sample;

   // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start_det) state_next = S_START;
         S_START:  if (sample) state_next = rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (sample && bit_idx == 3'd7) state_next = pen_q ? S_PARITY : S_STOP;
         S_PARITY: if (sample) state_next = S_STOP;
         S_STOP:   if (sample) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         pbit     <= 1'b0;
         baud_q   <= '0;
         pen_q    <= 1'b0;
         ohel_q   <= 1'b0;
         hold_low <= 1'b0;
         stop_q   <= 1'b1;
         perr_q   <= 1'b0;
         rx_data  <= '0;
         rxrdy    <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         ovf      <= 1'b0;
         rx_done  <= 1'b0;
      end else begin
         state   <= state_next;
         rx_meta <= rx;
         rx_s    <= rx_meta;
         cnt     <= (state == S_IDLE || sample) ? '0 : cnt + 1'b1;

         if (start_det) begin
            baud_q  <= baud_sel;
            pen_q   <= pen;
            ohel_q  <= ohel;
            bit_idx <= '0;
         end
         if (state == S_DATA && sample) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (state == S_PARITY && sample) pbit <= rx_s;

         // A break (stop bit low) must see the line return high before re-arming.
         if (frame_end)  hold_low <= ~rx_s;
         else if (rx_s)  hold_low <= 1'b0;

         rx_done <= frame_end;
         if (frame_end) begin
            stop_q <= rx_s;
            perr_q <= pen_q & ((^shift ^ pbit) != ohel_q);
         end

         // The holding register commits in the rx_done cycle, so an ack there loses to it.
         if (rx_done) begin
            rx_data <= shift;
            ferr    <= ~stop_q;
            perr    <= perr_q;
            ovf     <= rxrdy & ~rd_ack;
            rxrdy   <= 1'b1;
         end else if (rd_ack) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized self-checking bench for uart_rx_deframer; expectations come from a
// frame-level model (baud arithmetic, ones-count parity, holding-register rules).
module tb_uart_rx_deframer;

   localparam int CLK_HZ = 100000000;

   logic       clk = 1'b0;
   logic       reset, rx, pen, ohel, rd_ack;
   logic [3:0] baud_sel;
   logic [7:0] rx_data;
   logic       rxrdy, perr, ferr, ovf, rx_done;

   int errors = 0;
   int checks = 0;

   uart_rx_deframer #(.CLK_HZ(CLK_HZ), .CNT_W(19)) dut (
      .clk(clk), .reset(reset), .rx(rx), .baud_sel(baud_sel), .pen(pen), .ohel(ohel),
      .rd_ack(rd_ack), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr),
      .ovf(ovf), .rx_done(rx_done)
   );

   always #5 clk = ~clk;

   function automatic int bt_for(input int code);
      int rates [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                         115200, 230400, 460800, 921600};
      int b;
      b = (code < 12) ? rates[code] : 115200;
      return (CLK_HZ + b / 2) / b;
   endfunction

   // Negedges from driving the start edge to seeing rx_done: 2 synchronizer cycles plus frame latency.
   function automatic int exp_latency(input int bt, input logic p_en);
      return 2 + bt / 2 + (9 + (p_en ? 1 : 0)) * bt + 1;
   endfunction

   function automatic logic exp_perr(input logic [7:0] d, input logic p_en, input logic p_bit,
                                     input logic odd);
      int ones;
      ones = p_bit ? 1 : 0;
      for (int i = 0; i < 8; i++) if (d[i]) ones++;
      return p_en && ((ones % 2) != (odd ? 1 : 0));
   endfunction

   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
      @(negedge clk);
   endtask

   // Drives one frame from a negedge; a parallel watcher returns the negedge count to rx_done (-1 if none).
   task automatic run_frame(input logic [7:0] d, input logic p_en, input logic p_bit,
                            input logic stop_bit, input int bt, input bit ack_at_done,
                            input bit scramble, output int lat);
      lat = -1;
      fork
         begin
            rx = 1'b0;
            repeat (bt) @(negedge clk);
            if (scramble) begin
               baud_sel = 4'($urandom_range(0, 15));
               pen      = ~pen;
               ohel     = ~ohel;
            end
            for (int i = 0; i < 8; i++) begin
               rx = d[i];
               repeat (bt) @(negedge clk);
            end
            if (p_en) begin
               rx = p_bit;
               repeat (bt) @(negedge clk);
            end
            rx = stop_bit;
            repeat (bt) @(negedge clk);
            rx = 1'b1;
            repeat (4) @(negedge clk);
         end
         begin
            int n;
            n = 0;
            while (lat < 0 && n < 20 * bt) begin
               @(negedge clk);
               n++;
               if (rx_done) begin
                  lat = n;
                  if (ack_at_done) rd_ack = 1'b1;
               end
            end
            if (rd_ack) begin
               @(negedge clk);
               rd_ack = 1'b0;
            end
         end
      join
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
      checks++; if ({rxrdy, perr, ferr, ovf, rx_done} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {rxrdy, perr, ferr, ovf, rx_done}); end
   endtask

   task automatic test_basic_115200();
      int lat, bt;
      baud_sel = 4'd8; pen = 1'b0; ohel = 1'b0;
      bt = bt_for(8);
      run_frame(8'hA5, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      checks++; if (lat !== exp_latency(bt, 1'b0)) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_latency(bt, 1'b0)); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0h expected a5", rx_data); end
      checks++; if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin errors++; $display("FAIL basic_flags: got %b expected 1000", {rxrdy, perr, ferr, ovf}); end
      pulse_ack();
   endtask

   task automatic test_parity();
      int lat, bt;
      baud_sel = 4'd11; pen = 1'b1; ohel = 1'b0;
      bt = bt_for(11);
      run_frame(8'h03, 1'b1, 1'b1, 1'b1, bt, 1'b0, 1'b0, lat);
      checks++; if (lat !== exp_latency(bt, 1'b1)) begin errors++; $display("FAIL parity_latency: got %0d expected %0d", lat, exp_latency(bt, 1'b1)); end
      checks++; if ({rx_data, perr} !== {8'h03, 1'b1}) begin errors++; $display("FAIL parity_bad: got %0h/%b expected 03/1", rx_data, perr); end
      pulse_ack();
      run_frame(8'h03, 1'b1, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      checks++; if ({rx_data, perr, rxrdy} !== {8'h03, 1'b0, 1'b1}) begin errors++; $display("FAIL parity_good: got %0h/%b/%b expected 03/0/1", rx_data, perr, rxrdy); end
      pulse_ack();
      pen = 1'b0;
   endtask

   task automatic test_framing();
      int lat;
      baud_sel = 4'd11;
      run_frame(8'h7E, 1'b0, 1'b0, 1'b0, bt_for(11), 1'b0, 1'b0, lat);
      checks++; if ({rx_data, ferr, rxrdy} !== {8'h7E, 1'b1, 1'b1}) begin errors++; $display("FAIL framing_err: got %0h/%b/%b expected 7e/1/1", rx_data, ferr, rxrdy); end
      pulse_ack();
      checks++; if ({rx_data, ferr, rxrdy} !== {8'h7E, 1'b0, 1'b0}) begin errors++; $display("FAIL framing_ack: got %0h/%b/%b expected 7e/0/0", rx_data, ferr, rxrdy); end
   endtask

   task automatic test_glitch();
      int lat, dones;
      baud_sel = 4'd8;
      dones = 0;
      rx = 1'b0;
      repeat (200) @(negedge clk);
      rx = 1'b1;
      repeat (2000) begin
         @(negedge clk);
         if (rx_done) dones++;
      end
      checks++; if ({dones, rxrdy} !== {32'd0, 1'b0}) begin errors++; $display("FAIL glitch_ignored: got dones=%0d rxrdy=%b expected 0/0", dones, rxrdy); end
      run_frame(8'h55, 1'b0, 1'b0, 1'b1, bt_for(8), 1'b0, 1'b0, lat);
      checks++; if ({rx_data, rxrdy, ferr} !== {8'h55, 1'b1, 1'b0}) begin errors++; $display("FAIL glitch_then_frame: got %0h/%b/%b expected 55/1/0", rx_data, rxrdy, ferr); end
      pulse_ack();
   endtask

   task automatic test_overrun();
      int lat, bt;
      baud_sel = 4'd11;
      bt = bt_for(11);
      run_frame(8'h11, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      run_frame(8'h22, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      checks++; if ({rx_data, ovf, rxrdy} !== {8'h22, 1'b1, 1'b1}) begin errors++; $display("FAIL overrun: got %0h/%b/%b expected 22/1/1", rx_data, ovf, rxrdy); end
      pulse_ack();
      checks++; if ({ovf, rxrdy} !== 2'b00) begin errors++; $display("FAIL overrun_ack: got %b expected 00", {ovf, rxrdy}); end
      run_frame(8'h11, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      run_frame(8'h22, 1'b0, 1'b0, 1'b1, bt, 1'b1, 1'b0, lat);
      checks++; if (lat !== exp_latency(bt, 1'b0)) begin errors++; $display("FAIL ack_race_latency: got %0d expected %0d", lat, exp_latency(bt, 1'b0)); end
      checks++; if ({rx_data, ovf, rxrdy} !== {8'h22, 1'b0, 1'b1}) begin errors++; $display("FAIL ack_race: got %0h/%b/%b expected 22/0/1", rx_data, ovf, rxrdy); end
      pulse_ack();
   endtask

   task automatic test_reset_midframe();
      int lat, bt, dones;
      baud_sel = 4'd11;
      bt = bt_for(11);
      dones = 0;
      rx = 1'b0;
      repeat (bt) @(negedge clk);
      rx = 1'b1;
      repeat (3 * bt + bt / 2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({rx_data, rxrdy, perr, ferr, ovf} !== 12'h0) begin errors++; $display("FAIL midframe_reset: got %0h/%b expected 00/0000", rx_data, {rxrdy, perr, ferr, ovf}); end
      repeat (12 * bt) begin
         @(negedge clk);
         if (rx_done) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL aborted_frame: got dones=%0d expected 0", dones); end
      run_frame(8'h3C, 1'b0, 1'b0, 1'b1, bt, 1'b0, 1'b0, lat);
      checks++; if ({rx_data, rxrdy, perr, ferr, ovf} !== {8'h3C, 4'b1000}) begin errors++; $display("FAIL after_reset_frame: got %0h/%b expected 3c/1000", rx_data, {rxrdy, perr, ferr, ovf}); end
      pulse_ack();
   endtask

   task automatic test_break();
      int bt, dones;
      baud_sel = 4'd11; pen = 1'b0;
      bt = bt_for(11);
      dones = 0;
      rx = 1'b0;
      repeat (25 * bt) begin
         @(negedge clk);
         if (rx_done) dones++;
      end
      rx = 1'b1;
      repeat (4 * bt) begin
         @(negedge clk);
         if (rx_done) dones++;
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL break_frames: got %0d expected 1", dones); end
      checks++; if ({rx_data, ferr, rxrdy} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL break_data: got %0h/%b/%b expected 00/1/1", rx_data, ferr, rxrdy); end
      pulse_ack();
   endtask

   // Random bytes, rates, parity and corrupted bits; baud_sel/pen/ohel are scrambled mid-frame.
   task automatic test_random_frames();
      int lat, bt, code;
      logic [7:0] d;
      logic p, o, pb, sb;
      for (int k = 0; k < 10; k++) begin
         code = $urandom_range(9, 12);
         bt   = bt_for(code);
         d    = 8'($urandom);
         p    = 1'($urandom);
         o    = 1'($urandom);
         pb   = 1'($urandom);
         sb   = ($urandom_range(0, 3) != 0);
         baud_sel = 4'(code); pen = p; ohel = o;
         run_frame(d, p, pb, sb, bt, 1'b0, 1'b1, lat);
         checks++; if (lat !== exp_latency(bt, p)) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, exp_latency(bt, p)); end
         checks++; if (rx_data !== d) begin errors++; $display("FAIL rand%0d_data: got %0h expected %0h", k, rx_data, d); end
         checks++; if ({rxrdy, perr, ferr, ovf} !== {1'b1, exp_perr(d, p, pb, o), ~sb, 1'b0}) begin errors++; $display("FAIL rand%0d_flags: got %b expected %b", k, {rxrdy, perr, ferr, ovf}, {1'b1, exp_perr(d, p, pb, o), ~sb, 1'b0}); end
         pulse_ack();
      end
   endtask

   initial begin
      reset = 1'b1; rx = 1'b1; baud_sel = 4'd8; pen = 1'b0; ohel = 1'b0; rd_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_115200();
      test_parity();
      test_framing();
      test_glitch();
      test_overrun();
      test_reset_midframe();
      test_break();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
